// File: rtl/sad_block_feeder.sv
// Block SAD sequencer: reads blocks A and B word by word from two synchronous-read
// memories, streams the sample pairs into the AFD accumulator, waits out the AFD
// pipeline and returns the captured result with a one-cycle done pulse.
module sad_block_feeder #(
  parameter int unsigned Width  = 8,
  parameter int unsigned BlkLen = 16,
  parameter int unsigned AddrW  = 4,
  parameter int unsigned AfdLat = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [AddrW-1:0]     base_a_i,
  input  logic [AddrW-1:0]     base_b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [Width+7:0]     sad_out_o,
  output logic                 rd_en_o,
  output logic [AddrW-1:0]     addr_a_o,
  output logic [AddrW-1:0]     addr_b_o,
  input  logic [2*Width-1:0]   rdata_a_i,
  input  logic [2*Width-1:0]   rdata_b_i,
  output logic                 afd_en_o,
  output logic                 afd_acum_o,
  output logic [Width-1:0]     afd_a0_o,
  output logic [Width-1:0]     afd_b0_o,
  output logic [Width-1:0]     afd_a1_o,
  output logic [Width-1:0]     afd_b1_o,
  input  logic [Width+7:0]     afd_result_i
);

  localparam int unsigned Nw   = BlkLen / 2;
  localparam int unsigned CntW = (Nw > 1) ? $clog2(Nw) : 1;
  localparam int unsigned DrnW = $clog2(AfdLat + 1) + 1;

  localparam logic [CntW-1:0] LastWord  = CntW'(Nw - 1);
  localparam logic [DrnW-1:0] LastDrain = DrnW'(AfdLat);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StCapture} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   word_q, word_d;
  logic [DrnW-1:0]   drain_q, drain_d;
  logic [AddrW-1:0]  base_a_q, base_a_d;
  logic [AddrW-1:0]  base_b_q, base_b_d;
  logic [Width+7:0]  sad_q, sad_d;
  logic              done_q, done_d;
  logic              en_q, en_d;
  logic              acum_q, acum_d;

  logic              rd_en;
  logic              in_run;

  assign rd_en  = (state_q == StRead);
  assign in_run = (state_q != StIdle);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      word_q   <= '0;
      drain_q  <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      sad_q    <= '0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      acum_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      drain_q  <= drain_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      sad_q    <= sad_d;
      done_q   <= done_d;
      en_q     <= en_d;
      acum_q   <= acum_d;
    end
  end

  // Next-state: sequencing, counters, result capture and abort override.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    drain_d  = drain_q;
    base_a_d = base_a_q;
    base_b_d = base_b_q;
    sad_d    = sad_q;
    done_d   = 1'b0;
    // AFD beat is the read beat one cycle later; the first word of a block clears acum.
    en_d     = rd_en & ~abort_i;
    acum_d   = rd_en & (word_q != '0);

    unique case (state_q)
      StIdle: begin
        // No accept while the done pulse is still out, so back-to-back starts space by one.
        if (start_i && !abort_i && !done_q) begin
          state_d  = StRead;
          word_d   = '0;
          base_a_d = base_a_i;
          base_b_d = base_b_i;
        end
      end
      StRead: begin
        if (word_q == LastWord) begin
          state_d = StDrain;
          word_d  = '0;
          drain_d = '0;
        end else begin
          word_d = word_q + CntW'(1);
        end
      end
      StDrain: begin
        // Covers the memory read beat plus the AFD pipeline.
        if (drain_q == LastDrain) begin
          state_d = StCapture;
          drain_d = '0;
        end else begin
          drain_d = drain_q + DrnW'(1);
        end
      end
      StCapture: begin
        sad_d   = afd_result_i;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort_i && in_run) begin
      state_d = StIdle;
      word_d  = '0;
      drain_d = '0;
      sad_d   = sad_q;
      done_d  = 1'b0;
    end
  end

  // Output decode: memory side, AFD side and status.
  always_comb begin
    rd_en_o    = rd_en;
    addr_a_o   = rd_en ? (base_a_q + AddrW'(word_q)) : '0;
    addr_b_o   = rd_en ? (base_b_q + AddrW'(word_q)) : '0;
    afd_en_o   = en_q;
    afd_acum_o = en_q & acum_q;
    afd_a0_o   = in_run ? rdata_a_i[Width-1:0]       : '0;
    afd_a1_o   = in_run ? rdata_a_i[2*Width-1:Width] : '0;
    afd_b0_o   = in_run ? rdata_b_i[Width-1:0]       : '0;
    afd_b1_o   = in_run ? rdata_b_i[2*Width-1:Width] : '0;
    busy_o     = in_run | done_q;
    done_o     = done_q;
    sad_out_o  = sad_q;
  end

endmodule

// File: tb/tb_sad_block_feeder.sv
// Bench for sad_block_feeder: two 1-cycle synchronous RAMs, a behavioural AFD
// (two-stage accumulate, result scaled by 8) and a block-level SAD reference.
module tb_sad_block_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  base_a = '0, base_b = '0;
  logic        busy, done, rd_en, afd_en, afd_acum;
  logic [15:0] sad_out, afd_result;
  logic [3:0]  addr_a, addr_b;
  logic [15:0] rdata_a, rdata_b;
  logic [7:0]  a0, b0, a1, b1;

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sad_block_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .base_a_i     (base_a),
    .base_b_i     (base_b),
    .busy_o       (busy),
    .done_o       (done),
    .sad_out_o    (sad_out),
    .rd_en_o      (rd_en),
    .addr_a_o     (addr_a),
    .addr_b_o     (addr_b),
    .rdata_a_i    (rdata_a),
    .rdata_b_i    (rdata_b),
    .afd_en_o     (afd_en),
    .afd_acum_o   (afd_acum),
    .afd_a0_o     (a0),
    .afd_b0_o     (b0),
    .afd_a1_o     (a1),
    .afd_b1_o     (b1),
    .afd_result_i (afd_result)
  );

  function automatic int absd(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  // Synchronous-read memories.
  always @(posedge clk) begin
    if (rd_en) begin
      rdata_a <= mem_a[addr_a];
      rdata_b <= mem_b[addr_b];
    end
  end

  // AFD: accumulate on en (restart when acum=0), then register the scaled sum.
  logic [15:0] acc_q, out_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      if (afd_en) acc_q <= (afd_acum ? acc_q : 16'd0) + 16'(absd(a0, b0) + absd(a1, b1));
      out_q <= acc_q << 3;
    end
  end
  assign afd_result = out_q;

  function automatic logic [15:0] ref_sad(input logic [3:0] ba, input logic [3:0] bb);
    int sum;
    logic [15:0] wa, wb;
    sum = 0;
    for (int k = 0; k < 8; k++) begin
      wa = mem_a[(int'(ba) + k) % 16];
      wb = mem_b[(int'(bb) + k) % 16];
      sum += absd(wa[7:0], wb[7:0]) + absd(wa[15:8], wb[15:8]);
    end
    return 16'(sum * 8);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Per-run observations.
  int          lat, en_cnt, n_rd, busy_bad;
  logic [15:0] got_sad;
  logic [7:0]  acum_pat;
  logic [3:0]  addr_a_log [8];
  logic [3:0]  addr_b_log [8];

  task automatic run_block(input logic [3:0] ba, input logic [3:0] bb);
    lat = -1; en_cnt = 0; n_rd = 0; busy_bad = 0; got_sad = '0; acum_pat = '0;
    @(negedge clk);
    base_a = ba; base_b = bb; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en) begin
        if (n_rd < 8) begin
          addr_a_log[n_rd] = addr_a;
          addr_b_log[n_rd] = addr_b;
        end
        n_rd++;
      end
      if (afd_en) begin
        if (en_cnt < 8) acum_pat[en_cnt] = afd_acum;
        en_cnt++;
      end
      if (!busy) busy_bad++;
      if (done) begin
        lat = cyc;
        got_sad = sad_out;
      end
    end
  endtask

  task automatic check_run(input string tag, input logic [15:0] exp_sad);
    chk({tag, " latency"}, lat, 13);
    chk({tag, " sad"}, got_sad, exp_sad);
    chk({tag, " en_beats"}, en_cnt, 8);
    chk({tag, " rd_beats"}, n_rd, 8);
    chk({tag, " acum_pattern"}, acum_pat, 8'hFE);
    chk({tag, " busy_gap"}, busy_bad, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 16'($urandom);
      mem_b[i] = 16'($urandom);
    end
  endtask

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [3:0]  ba;
    logic [3:0]  bb;
    logic [15:0] exp_sad;
  } vec_t;

  vec_t        vecs [5];
  logic [15:0] last_exp;
  logic [3:0]  rba, rbb;
  int          seen, d1, d2;
  logic        acum_first2, en_first2, busy14;

  initial begin
    vecs[0] = '{va: 8'h37, vb: 8'h37, ba: 4'd0,  bb: 4'd8,  exp_sad: 16'd0};
    vecs[1] = '{va: 8'hFF, vb: 8'h00, ba: 4'd0,  bb: 4'd0,  exp_sad: 16'd32640};
    vecs[2] = '{va: 8'h10, vb: 8'h20, ba: 4'd5,  bb: 4'd9,  exp_sad: 16'd2048};
    vecs[3] = '{va: 8'h00, vb: 8'hFF, ba: 4'd12, bb: 4'd2,  exp_sad: 16'd32640};
    vecs[4] = '{va: 8'h80, vb: 8'h7F, ba: 4'd15, bb: 4'd1,  exp_sad: 16'd128};

    for (int i = 0; i < 16; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end

    repeat (3) @(negedge clk);
    chk("reset status", {busy, done, rd_en, afd_en, afd_acum}, 0);
    chk("reset sad_out", sad_out, 0);
    chk("reset addr", {addr_a, addr_b}, 0);
    chk("reset operands", {a0, b0, a1, b1}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Uniform-fill vectors.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] = {vecs[v].va, vecs[v].va};
        mem_b[i] = {vecs[v].vb, vecs[v].vb};
      end
      run_block(vecs[v].ba, vecs[v].bb);
      check_run($sformatf("vec%0d", v), vecs[v].exp_sad);
      last_exp = vecs[v].exp_sad;
    end

    // Address wrap with random contents.
    fill_random();
    run_block(4'd14, 4'd3);
    check_run("wrap", ref_sad(4'd14, 4'd3));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wrap addr_a[%0d]", k), addr_a_log[k], (14 + k) % 16);
      chk($sformatf("wrap addr_b[%0d]", k), addr_b_log[k], 3 + k);
    end
    last_exp = ref_sad(4'd14, 4'd3);

    // Random blocks and bases.
    for (int r = 0; r < 6; r++) begin
      fill_random();
      rba = 4'($urandom);
      rbb = 4'($urandom);
      run_block(rba, rbb);
      check_run($sformatf("rand%0d", r), ref_sad(rba, rbb));
      for (int k = 0; k < 8; k++)
        chk($sformatf("rand%0d addr_a[%0d]", r, k), addr_a_log[k], (int'(rba) + k) % 16);
      last_exp = ref_sad(rba, rbb);
    end

    // Start held high across two runs.
    fill_random();
    rba = 4'd7; rbb = 4'd11;
    d1 = -1; d2 = -1; acum_first2 = 1'b1; en_first2 = 1'b0; busy14 = 1'b1;
    @(negedge clk);
    base_a = rba; base_b = rbb; start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 60 && d2 < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 14) busy14 = busy;
      if (cyc == 16) begin
        en_first2 = afd_en;
        acum_first2 = afd_acum;
      end
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc;
          chk("b2b sad1", sad_out, ref_sad(rba, rbb));
        end else begin
          d2 = cyc;
          chk("b2b sad2", sad_out, ref_sad(rba, rbb));
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b done1 cycle", d1, 13);
    chk("b2b done2 cycle", d2, 27);
    chk("b2b busy gap", busy14, 0);
    chk("b2b second first en", en_first2, 1);
    chk("b2b second first acum", acum_first2, 0);
    last_exp = ref_sad(rba, rbb);

    // Abort in READ at the fourth word.
    fill_random();
    @(negedge clk);
    base_a = 4'd2; base_b = 4'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort pre rd_en", rd_en, 1);
    chk("abort pre addr_a", addr_a, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort rd_en drop", rd_en, 0);
    chk("abort busy drop", busy, 0);
    chk("abort afd_en drop", afd_en, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort no done", seen, 0);
    chk("abort sad held", sad_out, last_exp);

    // Start together with abort in IDLE is refused.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start+abort no accept", busy, 0);

    run_block(4'd9, 4'd0);
    check_run("post-abort", ref_sad(4'd9, 4'd0));

    // Reset pulse during DRAIN.
    fill_random();
    @(negedge clk);
    base_a = 4'd1; base_b = 4'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset mid status", {busy, done, rd_en, afd_en, afd_acum}, 0);
    chk("reset mid sad_out", sad_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("reset mid no done", seen, 0);

    fill_random();
    run_block(4'd13, 4'd10);
    check_run("post-reset", ref_sad(4'd13, 4'd10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
